// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, issues one imem request at a time,
// and hands {pc, pc+4, instr} to decode over a valid/ready handshake.

module pc_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = a + b;
endmodule

module fetch_pc_unit #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_pc_plus4,
    output logic [WIDTH-1:0] out_instr
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
    localparam logic [WIDTH-1:0] RESET_ADDR = RESET_PC & ALIGN_MASK;
    localparam logic [WIDTH-1:0] FOUR       = WIDTH'(4);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [WIDTH-1:0] next_pc_q, next_pc_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_pc_q, out_pc_d;
    logic [WIDTH-1:0] out_instr_q, out_instr_d;
    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] target;

    pc_adder #(.WIDTH(WIDTH)) u_seq_adder (
        .a (out_pc_q),
        .b (FOUR),
        .y (seq_pc)
    );

    assign target       = redirect_pc & ALIGN_MASK;
    assign imem_req     = (state_q == REQ) || (state_q == DROP);
    assign imem_addr    = fetch_addr_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_pc_plus4 = seq_pc;
    assign out_instr    = out_instr_q;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        next_pc_d    = next_pc_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_instr_d  = out_instr_q;
        unique case (state_q)
            IDLE: begin
                if (redirect_valid) fetch_addr_d = target;
                state_d = REQ;
            end
            REQ: begin
                if (redirect_valid) begin
                    // Data landing with a redirect is stale: refetch at once.
                    if (imem_ack) begin
                        fetch_addr_d = target;
                        state_d      = REQ;
                    end else begin
                        next_pc_d = target;
                        state_d   = DROP;
                    end
                end else if (imem_ack) begin
                    out_instr_d = imem_rdata;
                    out_pc_d    = fetch_addr_q;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    fetch_addr_d = target;
                    out_valid_d  = 1'b0;
                    state_d      = REQ;
                end else if (out_ready) begin
                    fetch_addr_d = seq_pc;
                    out_valid_d  = 1'b0;
                    state_d      = REQ;
                end
            end
            DROP: begin
                if (redirect_valid) next_pc_d = target;
                if (imem_ack) begin
                    fetch_addr_d = redirect_valid ? target : next_pc_q;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_addr_q <= RESET_ADDR;
            next_pc_q    <= RESET_ADDR;
            out_valid_q  <= 1'b0;
            out_pc_q     <= RESET_ADDR;
            out_instr_q  <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            next_pc_q    <= next_pc_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_instr_q  <= out_instr_d;
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, stalls, redirects,
// address wrap and asynchronous reset.

module tb_fetch_pc_unit;
    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_instr;

    int errors = 0;
    int checks = 0;

    fetch_pc_unit #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .out_instr      (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_req got=%b exp=0", imem_req);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_pc !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_pc got=%h/%h exp=0/0", out_pc, imem_addr);
        end
        checks++;
        if (out_instr !== 32'h0 || out_pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL rst_instr got=%h/%h exp=0/4", out_instr, out_pc_plus4);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] pc;
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0013;
        out_ready  = 1'b1;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            pc = 32'(4 * i);
            tick();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== pc || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL seq_req%0d got=%b/%h/%b exp=1/%h/0",
                         i, imem_req, imem_addr, out_valid, pc);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || imem_req !== 1'b0 || out_pc !== pc ||
                out_pc_plus4 !== pc + 32'h4 || out_instr !== 32'h13) begin
                errors++;
                $display("FAIL seq_out%0d got=%b/%b/%h/%h/%h exp=1/0/%h/%h/13",
                         i, out_valid, imem_req, out_pc, out_pc_plus4,
                         out_instr, pc, pc + 32'h4);
            end
        end
    endtask

    task automatic test_delayed_ack();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0013;
        out_ready  = 1'b1;
        apply_reset();
        tick();
        tick();
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h4 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dly_wait%0d got=%b/%h/%b exp=1/4/0",
                         k, imem_req, imem_addr, out_valid);
            end
            if (k < 2) tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_00A5;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== 32'hA5) begin
            errors++;
            $display("FAIL dly_out got=%b/%h/%h exp=1/4/a5",
                     out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_hold_stall();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h4 ||
                out_instr !== 32'hA5 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d got=%b/%h/%h/%b exp=1/4/a5/0",
                         k, out_valid, out_pc, out_instr, imem_req);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_rel got=%b/%h/%b exp=1/8/0",
                     imem_req, imem_addr, out_valid);
        end
    endtask

    task automatic test_redirect_drop();
        imem_ack       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL drop_wait%0d got=%b/%h/%b exp=1/8/0",
                         k, imem_req, imem_addr, out_valid);
            end
            if (k == 0) tick();
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 ||
            out_valid !== 1'b0 || out_instr !== 32'hA5) begin
            errors++;
            $display("FAIL drop_refetch got=%b/%h/%b/%h exp=1/100/0/a5",
                     imem_req, imem_addr, out_valid, out_instr);
        end
        imem_rdata = 32'h0000_0033;
        out_ready  = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h33) begin
            errors++;
            $display("FAIL drop_out got=%b/%h/%h exp=1/100/33",
                     out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_redirect_hold();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0020;
        imem_rdata     = 32'h0000_0077;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h20 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_redir got=%b/%h/%b exp=1/20/0",
                     imem_req, imem_addr, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== 32'h77) begin
            errors++;
            $display("FAIL hold_out20 got=%b/%h/%h exp=1/20/77",
                     out_valid, out_pc, out_instr);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0080;
        out_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_race got=%b/%h/%b exp=1/80/0",
                     imem_req, imem_addr, out_valid);
        end
        imem_rdata = 32'h0000_0088;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h80 || out_pc_plus4 !== 32'h84) begin
            errors++;
            $display("FAIL hold_out80 got=%b/%h/%h exp=1/80/84",
                     out_valid, out_pc, out_pc_plus4);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        imem_ack  = 1'b0;
        tick();
        imem_ack       = 1'b1;
        imem_rdata     = 32'h1111_1111;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0041;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40 ||
            out_valid !== 1'b0 || out_instr !== 32'h88) begin
            errors++;
            $display("FAIL req_ack_redir got=%b/%h/%b/%h exp=1/40/0/88",
                     imem_req, imem_addr, out_valid, out_instr);
        end
        imem_ack       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_pc    = 32'h0000_0402;
        imem_ack       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h400 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_last_wins got=%b/%h/%b exp=1/400/0",
                     imem_req, imem_addr, out_valid);
        end
    endtask

    task automatic test_wrap_and_reset();
        out_ready      = 1'b1;
        imem_ack       = 1'b1;
        imem_rdata     = 32'h0000_0099;
        tick();
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", imem_req, imem_addr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC ||
            out_pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_out got=%b/%h/%h exp=1/fffffffc/0",
                     out_valid, out_pc, out_pc_plus4);
        end
        out_ready = 1'b1;
        imem_ack  = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next got=%b/%h exp=1/0", imem_req, imem_addr);
        end
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_rst got=%b/%b exp=0/0", imem_req, out_valid);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL post_rst got=%b/%h exp=1/0", imem_req, imem_addr);
        end
    endtask

    initial begin
        rst_n          = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        #2;
        test_reset();
        test_sequential();
        test_delayed_ack();
        test_hold_stall();
        test_redirect_drop();
        test_redirect_hold();
        test_back_to_back();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end that owns the program counter.
- Issues one word request at a time to instruction memory over a req/ack handshake.
- Captures the returned instruction and presents {pc, pc+4, instr} to decode over a valid/ready handshake.
- Applies redirects (branch/jump targets) from execute. The next sequential PC is computed by instantiating the team's adder with b = 4.

Parameters:
- WIDTH, 32, address and instruction width in bits.
- RESET_PC, 32'h0000_0000, PC fetched first after reset release.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request outstanding.
- imem_addr  output  WIDTH  byte address of the outstanding request; bits [1:0] always 0.
- imem_ack  input  1  memory returns data this cycle; honoured only while imem_req=1.
- imem_rdata  input  WIDTH  instruction word, valid when imem_ack=1.
- redirect_valid  input  1  one-cycle pulse: replace PC.
- redirect_pc  input  WIDTH  new PC; bits [1:0] ignored and forced to 0.
- out_valid  output  1  instruction available to decode.
- out_ready  input  1  decode accepts this cycle.
- out_pc  output  WIDTH  address of out_instr.
- out_pc_plus4  output  WIDTH  out_pc + 4, modulo 2^WIDTH.
- out_instr  output  WIDTH  fetched instruction.

Behaviour:
Registers and reset
- Internal registers: state, fetch_addr (address of the outstanding request), next_pc (redirect target captured in DROP).
- While rst_n=0, asynchronously: state=IDLE, fetch_addr=RESET_PC, next_pc=RESET_PC, out_valid=0, out_pc=RESET_PC, out_instr=0.
- imem_req = (state==REQ || state==DROP), decoded combinationally from state.
- imem_addr = fetch_addr, held stable for as long as imem_req=1.

States
- IDLE: first cycle after reset release. Unconditionally moves to REQ.
- REQ: request outstanding.
  - On imem_ack: out_instr<=imem_rdata, out_pc<=fetch_addr, out_valid<=1, go to HOLD.
  - No ack: stay in REQ.
- HOLD: out_valid=1; out_pc and out_instr are stable.
  - On out_valid & out_ready: fetch_addr<=out_pc+4, out_valid<=0, go to REQ.
  - Result: at most one instruction every 2 cycles with a zero-wait memory.
- DROP: a redirect arrived while a request was outstanding. imem_addr stays at the old address until ack.
  - On ack: discard imem_rdata, fetch_addr<=next_pc, go to REQ.

Redirect (priority over all other events in the same cycle)
- Target t = {redirect_pc[WIDTH-1:2], 2'b00}.
- IDLE or HOLD: fetch_addr<=t, out_valid<=0, go to REQ. A simultaneous out_ready handshake in HOLD is cancelled: decode must not treat it as consumed, and execute flushes decode.
- REQ without ack: next_pc<=t, go to DROP.
- REQ with ack the same cycle: data discarded, out_valid stays 0, fetch_addr<=t, go to REQ.
- DROP: next_pc<=t (last redirect wins). If ack arrives the same cycle: fetch_addr<=t, go to REQ.

Arithmetic and stability
- out_pc_plus4 and the sequential PC are out_pc+4, truncated to WIDTH bits. 0xFFFF_FFFC wraps to 0x0000_0000 with no flag.
- out_pc, out_instr and out_pc_plus4 change only on the HOLD-entry edge or on reset; they are never X after reset.
- imem_ack while imem_req=0 is ignored.
- Reset asserted mid-request drops the request immediately; memory must tolerate imem_req falling without ack.

Test Plan:
- Reset release, zero-wait memory returning 0x0000_0013 always acked, out_ready=1: imem_addr sequence 0x0,0x4,0x8; out_valid pulses every 2nd cycle with out_pc=0x0,0x4,0x8 and out_pc_plus4=0x4,0x8,0xC.
- Ack delayed 3 cycles: imem_req high and imem_addr=0x4 constant for 3 cycles; one out_valid with out_pc=0x4 follows.
- out_ready=0 for 5 cycles in HOLD: out_valid, out_pc and out_instr are stable, and imem_req=0 throughout.
- redirect_valid with redirect_pc=0x103 during REQ, ack 2 cycles later carrying 0xDEADBEEF: the data is dropped and never appears on out_instr; next imem_addr=0x100; next out_pc=0x100.
- Redirect and out_ready in the same HOLD cycle (out_pc=0x20, target 0x80): next request is 0x80, not 0x24.
- fetch_addr=0xFFFF_FFFC, acked and consumed: out_pc_plus4=0x0000_0000 and the next imem_addr=0x0. Then rst_n pulsed low mid-request: imem_req=0 and out_valid=0 immediately, and the first request after release is RESET_PC.
